// File: rtl/nn_ser_pkg.sv
// Shared definitions for the vector serializer: state encoding and word-count helpers.
package nn_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2
    } ser_state_e;

    localparam int DW_DEF    = 8;
    localparam int O_VEC_DEF = 21;

    // Number of DW-bit words needed to carry an o_vec-bit vector (ceiling divide).
    function automatic int nwords(input int o_vec, input int dw);
        return (o_vec + dw - 1) / dw;
    endfunction

    // Width of the vector once zero-padded up to a whole number of words.
    function automatic int pad_width(input int o_vec, input int dw);
        return nwords(o_vec, dw) * dw;
    endfunction

endpackage

// File: rtl/vec_capture_reg.sv
// Load-enable shadow register with asynchronous active-low clear.
module vec_capture_reg #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Shadow copy: captured only on load so later input changes cannot leak in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/vec_serializer.sv
// Serializes an O_VEC-bit vector into DW-bit words, LSW first, with a last-beat flag.
// Optional trailing XOR checksum beat is enabled by defining VEC_SERIALIZER_CSUM_EN.
module vec_serializer
    import nn_ser_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int O_VEC = O_VEC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [O_VEC-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int NW = nwords(O_VEC, DW);
    localparam int PW = pad_width(O_VEC, DW);
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    ser_state_e        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              cap_s;
    logic [O_VEC-1:0]  shadow_s;
    logic [PW-1:0]     padded_s;
    logic [DW-1:0]     word_s;

    vec_capture_reg #(.W(O_VEC)) u_capture (
        .clk    (clk),
        .rst    (rst),
        .load_i (cap_s),
        .d_i    (in_vec),
        .q_o    (shadow_s)
    );

    // Zero-pad the shadow to whole words and pick the word addressed by idx.
    always_comb begin
        padded_s = '0;
        padded_s[O_VEC-1:0] = shadow_s;
        word_s = padded_s[idx_q*DW +: DW];
    end

`ifdef VEC_SERIALIZER_CSUM_EN
    logic [DW-1:0] csum_s;

    // Checksum beat: XOR of every padded word of the shadow.
    always_comb begin
        csum_s = '0;
        for (int k = 0; k < NW; k++) begin
            csum_s = csum_s ^ padded_s[k*DW +: DW];
        end
    end
`endif

    // State and word-index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; outputs decode only registered state, shadow and idx.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cap_s     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cap_s   = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = word_s;
`ifdef VEC_SERIALIZER_CSUM_EN
                out_last  = 1'b0;
`else
                out_last  = (idx_q == LAST_IDX);
`endif
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef VEC_SERIALIZER_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_CSUM: begin
`ifdef VEC_SERIALIZER_CSUM_EN
                out_valid = 1'b1;
                out_data  = csum_s;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CSUM;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_vec_serializer.sv
// Directed self-checking bench for vec_serializer (default and VEC_SERIALIZER_CSUM_EN builds).
module tb_vec_serializer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    int checks_cnt;
    int errors_cnt;

`ifdef VEC_SERIALIZER_CSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    vec_serializer #(.DW(8), .O_VEC(21)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a vector at a negedge, let it be taken, return at the following negedge.
    task automatic send_vec(input string tag, input logic [20:0] v);
        @(negedge clk);
        in_vec   = v;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat_busy"}, 32'(busy), 32'd1);
        chk({tag, "_lat_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    // Consume NB beats, optionally stalling every other cycle; returns at the negedge after the last accept.
    task automatic rx(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                      input logic [7:0] w2, input logic [7:0] w3, input bit tog);
        logic [7:0] ew [4];
        int b;
        int cyc;
        bit ph;
        ew[0] = w0; ew[1] = w1; ew[2] = w2; ew[3] = w3;
        b = 0; cyc = 0; ph = 1'b0;
        while (b < NB && cyc < 40) begin
            chk($sformatf("%s_valid%0d", tag, b), 32'(out_valid), 32'd1);
            if (out_valid) begin
                chk($sformatf("%s_data%0d", tag, b), 32'(out_data), 32'(ew[b]));
                chk($sformatf("%s_last%0d", tag, b), 32'(out_last), (b == NB-1) ? 32'd1 : 32'd0);
                if (tog && !ph) begin
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    b++;
                end
                ph = !ph;
            end else begin
                out_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_beats"}, 32'(b), 32'(NB));
        if (!tog) chk({tag, "_cycles"}, 32'(cyc), 32'(NB));
        chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 21'h0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic stream with consumer always ready.
        send_vec("v1", 21'h1ABCDE);
        rx("v1", 8'hDE, 8'hBC, 8'h1A, 8'h78, 1'b0);

        // Consumer stalls every other cycle.
        send_vec("stall", 21'h1ABCDE);
        rx("stall", 8'hDE, 8'hBC, 8'h1A, 8'h78, 1'b1);

        // All-ones: padded top word.
        send_vec("ones", 21'h1FFFFF);
        rx("ones", 8'hFF, 8'hFF, 8'h1F, 8'h1F, 1'b0);

        // Input changes and in_valid pulses during SEND must not disturb the stream.
        send_vec("iso", 21'h1ABCDE);
        in_vec   = 21'h0F0F0F;
        in_valid = 1'b1;
        chk("iso_in_ready_send", 32'(in_ready), 32'd0);
        rx("iso", 8'hDE, 8'hBC, 8'h1A, 8'h78, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("iso_no_recapture", 32'(out_valid), 32'd0);
        chk("iso_no_recapture_busy", 32'(busy), 32'd0);

        // Reset after the first word is accepted.
        send_vec("mid", 21'h1ABCDE);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("mid_word1", 32'(out_data), 32'h0BC);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_post_valid", 32'(out_valid), 32'd0);
        send_vec("post", 21'h000001);
        rx("post", 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/vec_serializer.md
# vec_serializer

Drains a parallel O_VEC-bit result vector, such as the 21-bit network output register, onto a DW-bit word stream toward the host or readout side. It accepts one vector with a valid/ready handshake and holds it in an internal shadow register. It then emits the vector as ceil(O_VEC/DW) words, least-significant word first, over a second valid/ready handshake, and marks the final beat.

## Interface
- DW, 8, output word width in bits
- O_VEC, 21, input vector width in bits; NWORDS = ceil(O_VEC/DW), which is 3 at the defaults
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset; a low level clears all state immediately
- in_valid  input  1  producer has a vector on in_vec
- in_ready  output  1  block can accept a vector
- in_vec  input  O_VEC  parallel result vector
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer accepts the word
- out_data  output  DW  current word
- out_last  output  1  current word is the final beat of the vector
- busy  output  1  high whenever the block is not in IDLE

## Operation
- FSM states are IDLE and SEND (plus CSUM when the checksum feature is compiled in). A word index idx counts 0..NWORDS-1.
- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: shadow<=in_vec, idx<=0, go to SEND.
- SEND
  - in_ready=0, out_valid=1.
  - out_data = shadow[idx*DW +: DW]. Bits at or above O_VEC read as 0 (top word zero-padded).
  - On out_ready: if idx==NWORDS-1, go to IDLE, or to CSUM if the feature is enabled. Otherwise idx<=idx+1.
- out_last=1 only on the final beat: idx==NWORDS-1 in SEND without the feature, or the CSUM beat with it.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable. out_valid never drops until the word is accepted.
- in_vec changes during SEND have no effect because the shadow register is isolated.
- in_valid is ignored outside IDLE. There is no overlap between vectors.
- Reset values: state IDLE, idx 0, shadow 0, out_valid 0, out_data 0, out_last 0, busy 0, in_ready 1 (combinational from IDLE).
- Reset asserted mid-vector discards the remaining words. No partial beat is emitted after reset deasserts.

## Timing
- Vector accepted at edge N gives out_valid=1 in cycle N+1. The first word is visible with one cycle of latency.
- With out_ready held at 1, words appear in cycles N+1..N+NWORDS and IDLE resumes in cycle N+NWORDS+1. The checksum feature adds one cycle to both.
- Sustained throughput is one vector per NWORDS+1 cycles, or NWORDS+2 with the checksum.
- in_ready and out_valid are pure decodes of registered state. out_data is a mux of registered shadow and idx. There is no combinational path from any input to any output.

## Configuration
- Macro VEC_SERIALIZER_CSUM_EN.
- Defined: after the last data word the block emits one extra beat in the CSUM state.
  - out_data = XOR of all NWORDS (padded) words, computed from shadow.
  - out_last=1 on this beat. Data words then carry out_last=0.
  - Acceptance of the checksum beat returns the FSM to IDLE.
- Undefined: the CSUM state and XOR logic are absent, and the stream is exactly NWORDS beats.

## Structure
- Shared package nn_ser_pkg holds:
  - the state encoding constants (IDLE, SEND, CSUM)
  - the NWORDS ceil-divide function
  - the padded-word width constant
- Natural sub-module: vec_capture_reg, a parameterized load-enable register with asynchronous active-low clear, holding the shadow copy of in_vec. The FSM, index counter and output mux stay in vec_serializer.

## Test plan
- Reset, then in_vec=21'h1ABCDE with out_ready=1 gives words 8'hDE, 8'hBC, 8'h1A in consecutive cycles, out_last only on 8'h1A, and in_ready high again in the next cycle.
- Same vector with the checksum feature enabled gives 8'hDE, 8'hBC, 8'h1A, then 8'h78 with out_last=1 on 8'h78 only.
- Same vector with out_ready toggling 0/1 each cycle: each word holds stable while stalled, with no drops or duplicates.
- All-ones vector 21'h1FFFFF: top word is 8'h1F (padding zero). Checksum is 8'h1F when enabled.
- Change in_vec and pulse in_valid during SEND: emitted words match the captured vector, in_ready stays 0, and no second capture occurs.
- Drive rst low after the first word is accepted: outputs take reset values immediately. After release, a new vector 21'h000001 streams 8'h01, 8'h00, 8'h00.
